pulp_run_ctrl: RTL and testbench
================================

# pulp_run_ctrl

Run-control sequencer for the FPGA emulation top. It sits in the ps7_clk domain between the PS-side control/status registers and the PULPino SoC. On a start request from the PS it drives the SoC clock/reset generator's reset, waits for clocks to settle, asserts fetch enable, and watches end-of-computation. It then reports result, timeout and run-cycle count back to the PS.

## Interface
Parameters:
- RST_CYCLES, 16: cycles pulp_rst_n_o is held low per run (≥1).
- SETTLE_CYCLES, 64: cycles between reset release and fetch_en_o (≥1).

Ports:
- ps7_clk  in  1  clock.
- ps7_rst_pulp_n  in  1  reset, asynchronous, active-low.
- ctrl_i  in  32  PS control word; bit0 = run request (level), other bits ignored.
- timeout_i  in  32  run timeout in RUN cycles; 0 = no timeout; sampled every cycle.
- eoc_i  in  1  SoC end-of-computation, asynchronous to ps7_clk.
- return_i  in  2  SoC return code; stable while eoc_i high.
- pulp_rst_n_o  out  1  drives clk_rst_gen rst_ni.
- fetch_en_o  out  1  drives SoC fetch enable.
- status_o  out  32  end_of_operation word to PS.
- cycles_o  out  32  RUN cycle count.

## Operation
- eoc_i passes a 2-flop synchronizer (eoc_s); return_i is captured into ret_q on the cycle eoc_s is acted on.
- A start is a rising edge of ctrl_i[0], detected against a registered copy.
- States: IDLE, RESET, SETTLE, RUN, DONE, TIMEOUT. A single down-counter times RESET and SETTLE.

State behaviour:
- IDLE: rst low, fetch low. On start → RESET. Entering RESET clears the done, timeout, abort and ret_q flags and zeroes cycles_o.
- RESET: rst low for RST_CYCLES cycles, then → SETTLE.
- SETTLE: rst high, fetch low for SETTLE_CYCLES cycles, then → RUN. eoc_s is ignored here.
- RUN: rst high, fetch high. cycles_o increments each RUN cycle and saturates at 0xFFFFFFFF.
  - If eoc_s=1 → DONE and ret_q ← return_i.
  - Else if timeout_i≠0 and cycles_o = timeout_i−1 → TIMEOUT. RUN therefore lasts exactly timeout_i cycles, and cycles_o ends at timeout_i.
- DONE / TIMEOUT: fetch low, rst stays high so the PS can inspect SoC memory. Stay until ctrl_i[0]=0, then → IDLE; flags persist.

Abort and priority:
- ctrl_i[0]=0 while in RESET, SETTLE or RUN → IDLE with abort=1.
- Priority when events coincide: abort > eoc > timeout.
- A new start requires ctrl_i[0] to return to 0 first.

status_o bits:
- [0] done.
- [2:1] ret_q.
- [3] timeout.
- [4] abort.
- [5] busy (RESET, SETTLE or RUN).
- [8:6] state: IDLE=0, RESET=1, SETTLE=2, RUN=3, DONE=4, TIMEOUT=5.
- [31:9] = 0.

## Timing
- Reset values: pulp_rst_n_o=0, fetch_en_o=0, status_o=0, cycles_o=0, state IDLE, synchronizer and edge register 0.
- Reset mid-run returns everything to these values immediately (async); no completion is reported.
- All outputs are registered.
- Start and reset:
  - ctrl_i[0] rises before edge k → state RESET after edge k+1.
  - pulp_rst_n_o rises after edge k+1+RST_CYCLES.
  - fetch_en_o rises after edge k+1+RST_CYCLES+SETTLE_CYCLES.
- eoc latency: eoc_i high before edge e → eoc_s high after e+1 → DONE after e+2, with fetch_en_o low and status_o[0]=1 in that same cycle.
- Abort latency: ctrl_i[0] falls before edge a → IDLE (rst and fetch low) after edge a+1.
- timeout_i changes take effect on the next RUN cycle comparison.

## Test plan
- Normal run, RST_CYCLES=16, SETTLE_CYCLES=64, timeout_i=0:
  - Stimulus: start; raise eoc_i with return_i=2'b10 after 500 RUN cycles.
  - Required: rst low for exactly 16 cycles, fetch high 64 cycles after rst rises; DONE with status_o=0x00000105, cycles_o=500 (±2 sync cycles, checked exactly by the model).
- Timeout: timeout_i=100, eoc_i held 0 → TIMEOUT after exactly 100 fetch-high cycles, cycles_o=100, status_o=0x00000148.
- Abort in SETTLE: drop ctrl_i[0] mid-SETTLE → IDLE, pulp_rst_n_o=0, fetch_en_o=0, status_o=0x00000010; a following start clears abort.
- eoc and timeout coincident: eoc_s reaches the FSM on the RUN cycle where cycles_o=timeout_i−1 → DONE, timeout bit 0.
- Async reset asserted during RUN → all outputs 0 immediately. After release with ctrl_i[0] still 1 → no start until ctrl_i[0] toggles 0→1.
- Spurious eoc_i high during RESET/SETTLE is ignored. Re-run from DONE: drop ctrl_i[0] → IDLE, then start → flags and cycles_o cleared on entering RESET.

Source files
------------

// File: rtl/pulp_run_ctrl_if.sv
// PS <-> run-control handshake bundle: control/timeout in, SoC eoc/return in, SoC drive and status out.
// Latency: none, wires only.
// Backpressure: none; all signals are level-based.
interface pulp_run_ctrl_if;
    logic [31:0] ctrl_i;
    logic [31:0] timeout_i;
    logic        eoc_i;
    logic [1:0]  return_i;
    logic        pulp_rst_n_o;
    logic        fetch_en_o;
    logic [31:0] status_o;
    logic [31:0] cycles_o;

    modport slave (
        input  ctrl_i, timeout_i, eoc_i, return_i,
        output pulp_rst_n_o, fetch_en_o, status_o, cycles_o
    );

    modport master (
        output ctrl_i, timeout_i, eoc_i, return_i,
        input  pulp_rst_n_o, fetch_en_o, status_o, cycles_o
    );
endinterface

// File: rtl/pulp_run_ctrl.sv
// PULPino run-control sequencer: reset -> settle -> fetch-enable -> wait for eoc/timeout, report to PS.
// Latency: start edge to RESET 2 cycles; eoc_i to DONE 2 cycles (sync); abort to IDLE 2 cycles; outputs registered.
// Backpressure: none; run request is a level, a new run needs ctrl_i[0] to drop and rise again.
module pulp_run_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic           ps7_clk,
    input  logic           ps7_rst_pulp_n,
    pulp_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    localparam logic [31:0] RST_LOAD    = 32'(RST_CYCLES - 1);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

    // Only bit 0 of the control word carries meaning.
    logic [30:0] ctrl_unused;
    assign ctrl_unused = bus.ctrl_i[31:1];

    logic        eoc_meta_q, eoc_s_q;
    logic        ctrl_q, ctrl_prev_q;
    logic [1:0]  smp_vld_q;
    logic        start;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cycles_q, cycles_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        abort_q, abort_d;
    logic [1:0]  ret_q, ret_d;

    logic        rst_n_q, fetch_q, busy_q;

    // A rising edge only counts once two real samples exist, so a request
    // already high when reset releases does not launch a run.
    assign start = ctrl_q & ~ctrl_prev_q & smp_vld_q[1];

    // Synchronise eoc, register the run request and its previous sample.
    always_ff @(posedge ps7_clk or negedge ps7_rst_pulp_n) begin
        if (!ps7_rst_pulp_n) begin
            eoc_meta_q  <= 1'b0;
            eoc_s_q     <= 1'b0;
            ctrl_q      <= 1'b0;
            ctrl_prev_q <= 1'b0;
            smp_vld_q   <= 2'b00;
        end else begin
            eoc_meta_q  <= bus.eoc_i;
            eoc_s_q     <= eoc_meta_q;
            ctrl_q      <= bus.ctrl_i[0];
            ctrl_prev_q <= ctrl_q;
            smp_vld_q   <= {smp_vld_q[0], 1'b1};
        end
    end

    // FSM state, phase counter, run-cycle counter and result flags.
    always_ff @(posedge ps7_clk or negedge ps7_rst_pulp_n) begin
        if (!ps7_rst_pulp_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
            ret_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cycles_q  <= cycles_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
            ret_q     <= ret_d;
        end
    end

    // Next-state logic; abort beats eoc, eoc beats timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cycles_d  = cycles_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        abort_d   = abort_q;
        ret_d     = ret_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RESET;
                    cnt_d     = RST_LOAD;
                    cycles_d  = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    abort_d   = 1'b0;
                    ret_d     = 2'b00;
                end
            end
            ST_RESET: begin
                if (!ctrl_q) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_SETTLE: begin
                // eoc is deliberately not looked at until fetch is enabled.
                if (!ctrl_q) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (!ctrl_q) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (eoc_s_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ret_d   = bus.return_i;
                end else if ((bus.timeout_i != '0) && (cycles_q == bus.timeout_i - 32'd1)) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                // SoC reset stays released so the PS can read SoC memory.
                if (!ctrl_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output drive registered from the next state so it lines up with state_q.
    always_ff @(posedge ps7_clk or negedge ps7_rst_pulp_n) begin
        if (!ps7_rst_pulp_n) begin
            rst_n_q <= 1'b0;
            fetch_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rst_n_q <= (state_d != ST_IDLE) && (state_d != ST_RESET);
            fetch_q <= (state_d == ST_RUN);
            busy_q  <= (state_d == ST_RESET) || (state_d == ST_SETTLE) || (state_d == ST_RUN);
        end
    end

    assign bus.pulp_rst_n_o = rst_n_q;
    assign bus.fetch_en_o   = fetch_q;
    assign bus.cycles_o     = cycles_q;
    assign bus.status_o     = {23'd0, state_q, busy_q, abort_q, timeout_q, ret_q, done_q};

endmodule

// File: tb/tb_pulp_run_ctrl.sv
// Bench for pulp_run_ctrl: phase-timeline model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_pulp_run_ctrl;

    localparam int R = 16;
    localparam int S = 64;

    logic ps7_clk;
    logic ps7_rst_pulp_n;
    int   checks = 0;
    int   errors = 0;

    pulp_run_ctrl_if bus ();

    pulp_run_ctrl #(.RST_CYCLES(R), .SETTLE_CYCLES(S)) dut (
        .ps7_clk        (ps7_clk),
        .ps7_rst_pulp_n (ps7_rst_pulp_n),
        .bus            (bus)
    );

    initial begin
        ps7_clk = 1'b0;
        forever #5 ps7_clk = ~ps7_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- model: a run is a timeline measured from RESET entry
    localparam int M_IDLE = 0, M_ACT = 1, M_DONE = 2, M_TO = 3;
    int          m_mode  = M_IDLE;
    int          m_t     = 0;       // cycles since RESET entry while active
    logic [31:0] m_cyc   = '0;      // frozen run-cycle count
    logic        m_done  = 0, m_to = 0, m_abort = 0;
    logic [1:0]  m_ret   = 0;
    int          m_ns    = 0;       // samples of ctrl taken since reset (capped)
    logic        c_cur = 0, c_prev = 0, e_cur = 0, e_prev = 0;

    initial begin
        forever begin
            @(posedge ps7_clk or negedge ps7_rst_pulp_n);
            if (!ps7_rst_pulp_n) begin
                m_mode = M_IDLE; m_t = 0; m_cyc = '0;
                m_done = 0; m_to = 0; m_abort = 0; m_ret = 0;
                m_ns = 0; c_cur = 0; c_prev = 0; e_cur = 0; e_prev = 0;
            end else begin
                int  ridx;
                bit  in_run;
                ridx   = m_t - (R + S);
                in_run = (m_mode == M_ACT) && (m_t >= R + S);
                case (m_mode)
                    M_IDLE: if (m_ns >= 2 && c_cur && !c_prev) begin
                        m_mode = M_ACT; m_t = 0; m_cyc = '0;
                        m_done = 0; m_to = 0; m_abort = 0; m_ret = 0;
                    end
                    M_ACT: begin
                        if (!c_cur) begin
                            m_mode = M_IDLE; m_abort = 1;
                            if (in_run) m_cyc = 32'(ridx + 1);
                        end else if (in_run && e_prev) begin
                            m_mode = M_DONE; m_done = 1; m_ret = bus.return_i;
                            m_cyc = 32'(ridx + 1);
                        end else if (in_run && bus.timeout_i != 0 && 32'(ridx) == bus.timeout_i - 32'd1) begin
                            m_mode = M_TO; m_to = 1; m_cyc = 32'(ridx + 1);
                        end else begin
                            m_t++;
                        end
                    end
                    default: if (!c_cur) m_mode = M_IDLE;
                endcase
                c_prev = c_cur; c_cur = bus.ctrl_i[0];
                e_prev = e_cur; e_cur = bus.eoc_i;
                if (m_ns < 2) m_ns++;
            end
        end
    end

    // Compare every cycle against the model.
    initial begin
        forever begin
            logic [2:0]  st;
            logic        busy, exp_rst, exp_fetch;
            logic [31:0] exp_cyc;
            @(negedge ps7_clk);
            busy = (m_mode == M_ACT);
            case (m_mode)
                M_ACT:   st = (m_t < R) ? 3'd1 : (m_t < R + S) ? 3'd2 : 3'd3;
                M_DONE:  st = 3'd4;
                M_TO:    st = 3'd5;
                default: st = 3'd0;
            endcase
            exp_rst   = (m_mode != M_IDLE) && !(m_mode == M_ACT && m_t < R);
            exp_fetch = (m_mode == M_ACT) && (m_t >= R + S);
            exp_cyc   = exp_fetch ? 32'(m_t - (R + S)) : m_cyc;
            chk("model_rst_n", {31'd0, bus.pulp_rst_n_o}, {31'd0, exp_rst});
            chk("model_fetch", {31'd0, bus.fetch_en_o}, {31'd0, exp_fetch});
            chk("model_status", bus.status_o, {23'd0, st, busy, m_abort, m_to, m_ret, m_done});
            chk("model_cycles", bus.cycles_o, exp_cyc);
        end
    end

    // ---------------- directed stimulus
    task automatic tick(input int n);
        repeat (n) @(negedge ps7_clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (bus.status_o[8:6] != st && n < budget) begin
            @(negedge ps7_clk);
            n++;
        end
        chk(name, {29'd0, bus.status_o[8:6]}, {29'd0, st});
    endtask

    task automatic wait_cyc(input logic [31:0] v, input int budget, input string name);
        int n = 0;
        while (bus.cycles_o != v && n < budget) begin
            @(negedge ps7_clk);
            n++;
        end
        chk(name, bus.cycles_o, v);
    endtask

    initial begin
        int n;
        ps7_rst_pulp_n = 1'b1;
        bus.ctrl_i = '0; bus.timeout_i = '0; bus.eoc_i = 1'b0; bus.return_i = 2'b00;
        #1 ps7_rst_pulp_n = 1'b0;
        tick(3);
        chk("reset_rst_n", {31'd0, bus.pulp_rst_n_o}, 32'd0);
        chk("reset_fetch", {31'd0, bus.fetch_en_o}, 32'd0);
        chk("reset_status", bus.status_o, 32'd0);
        chk("reset_cycles", bus.cycles_o, 32'd0);
        ps7_rst_pulp_n = 1'b1;
        tick(3);

        // Normal run, eoc after 500 RUN cycles.
        bus.ctrl_i = 32'h0000_0001;
        wait_state(3'd1, 10, "norm_enter_reset");
        n = 0;
        while (bus.pulp_rst_n_o == 1'b0 && n < 100) begin n++; @(negedge ps7_clk); end
        chk("norm_rst_low_len", n, 16);
        n = 0;
        while (bus.fetch_en_o == 1'b0 && n < 200) begin n++; @(negedge ps7_clk); end
        chk("norm_settle_len", n, 64);
        wait_cyc(32'd499, 600, "norm_run_499");
        bus.eoc_i = 1'b1; bus.return_i = 2'b10;
        wait_state(3'd4, 10, "norm_done");
        chk("norm_status", bus.status_o, 32'h0000_0105);
        chk("norm_cycles", bus.cycles_o, 32'd502);
        chk("norm_fetch_low", {31'd0, bus.fetch_en_o}, 32'd0);
        chk("norm_rst_high", {31'd0, bus.pulp_rst_n_o}, 32'd1);
        bus.eoc_i = 1'b0; bus.ctrl_i = '0;
        tick(3);
        chk("norm_idle_flags", bus.status_o, 32'h0000_0005);

        // Timeout after exactly 100 fetch-high cycles.
        bus.timeout_i = 32'd100; bus.ctrl_i = 32'h0000_0001;
        n = 0;
        for (int i = 0; i < 400 && bus.status_o[8:6] != 3'd5; i++) begin
            @(negedge ps7_clk);
            if (bus.fetch_en_o) n++;
        end
        chk("to_fetch_high_len", n, 100);
        chk("to_status", bus.status_o, 32'h0000_0148);
        chk("to_cycles", bus.cycles_o, 32'd100);
        bus.ctrl_i = '0; bus.timeout_i = '0;
        tick(3);

        // Abort in SETTLE, then restart clears abort.
        bus.ctrl_i = 32'h0000_0001;
        wait_state(3'd2, 40, "abort_reach_settle");
        tick(20);
        bus.ctrl_i = '0;
        tick(3);
        chk("abort_rst_n", {31'd0, bus.pulp_rst_n_o}, 32'd0);
        chk("abort_fetch", {31'd0, bus.fetch_en_o}, 32'd0);
        chk("abort_status", bus.status_o, 32'h0000_0010);
        bus.ctrl_i = 32'h0000_0001;
        tick(3);
        chk("restart_status", bus.status_o, 32'h0000_0060);
        bus.ctrl_i = '0;
        tick(3);

        // eoc and timeout reach the FSM on the same cycle: eoc wins.
        bus.timeout_i = 32'd50; bus.ctrl_i = 32'h0000_0001;
        wait_state(3'd3, 120, "coinc_run");
        wait_cyc(32'd47, 60, "coinc_run_47");
        bus.eoc_i = 1'b1; bus.return_i = 2'b01;
        wait_state(3'd4, 10, "coinc_done");
        chk("coinc_status", bus.status_o, 32'h0000_0103);
        chk("coinc_cycles", bus.cycles_o, 32'd50);
        bus.eoc_i = 1'b0; bus.ctrl_i = '0; bus.timeout_i = '0;
        tick(3);

        // Async reset during RUN; request held high afterwards must not start.
        bus.ctrl_i = 32'h0000_0001;
        wait_state(3'd3, 120, "arst_run");
        tick(10);
        #2 ps7_rst_pulp_n = 1'b0;
        #1;
        chk("arst_rst_n", {31'd0, bus.pulp_rst_n_o}, 32'd0);
        chk("arst_fetch", {31'd0, bus.fetch_en_o}, 32'd0);
        chk("arst_status", bus.status_o, 32'd0);
        chk("arst_cycles", bus.cycles_o, 32'd0);
        @(negedge ps7_clk);
        ps7_rst_pulp_n = 1'b1;
        tick(20);
        chk("arst_no_start", bus.status_o, 32'd0);
        bus.ctrl_i = '0;
        tick(3);
        bus.ctrl_i = 32'h0000_0001;
        wait_state(3'd1, 10, "arst_toggle_start");

        // Spurious eoc during RESET/SETTLE, then finish and re-run from DONE.
        tick(5);
        bus.eoc_i = 1'b1; bus.return_i = 2'b11;
        tick(30);
        bus.eoc_i = 1'b0;
        wait_state(3'd3, 100, "spur_reach_run");
        tick(20);
        chk("spur_still_run", bus.status_o, 32'h0000_00E0);
        bus.eoc_i = 1'b1;
        wait_state(3'd4, 10, "spur_done");
        chk("spur_done_status", bus.status_o, 32'h0000_0107);
        bus.eoc_i = 1'b0; bus.ctrl_i = '0;
        tick(3);
        chk("rerun_idle", bus.status_o, 32'h0000_0007);
        bus.ctrl_i = 32'h0000_0001;
        wait_state(3'd1, 10, "rerun_reset");
        chk("rerun_status", bus.status_o, 32'h0000_0060);
        chk("rerun_cycles", bus.cycles_o, 32'd0);
        bus.ctrl_i = '0;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
